// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS_N/MOSI in the clk domain, shifts received
// bytes into an RX FIFO and returns bytes from a one-byte TX holding register.
module spi_slave #(
  parameter int unsigned RX_DEPTH  = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_clk,
  input  logic                      spi_cs_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  input  logic [1:0]                conf,
  input  logic [7:0]                tx_data,
  input  logic                      tx_load,
  output logic                      tx_empty,
  output logic [7:0]                rx_data,
  input  logic                      rx_read,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      rx_overrun,
  input  logic                      overrun_clr,
  output logic                      busy
);

  localparam int unsigned PTR_W = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sclk_q, cs_q;
  logic [1:0]         mosi_q;
  logic               cpol_q, cpha_q;
  logic [2:0]         bit_cnt_q;
  logic [6:0]         rx_sh_q;
  logic [7:0]         tx_sh_q;
  logic               first_shift_q, reload_pend_q;
  logic [7:0]         hold_q;
  logic [7:0]         mem_q [RX_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;

  logic sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c, mosi_c;
  logic active_c, start_c, stop_c;
  logic lead_c, trail_c, sample_c, shift_c, last_c, consume_c;
  logic do_push_c, do_read_c, overrun_set_c, full_c;
  logic [7:0] next_tx_c, push_data_c;

  // Two-flop synchronizers plus a history bit for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign sclk_rise_c = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_c = ~sclk_q[1] & sclk_q[2];
  assign cs_fall_c   = ~cs_q[1] & cs_q[2];
  assign cs_rise_c   = cs_q[1] & ~cs_q[2];
  assign mosi_c      = mosi_q[1];

  // Select state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Select next-state and transfer start/stop pulses
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    stop_c  = 1'b0;
    unique case (state_q)
      IDLE:   if (cs_fall_c) begin state_d = ACTIVE; start_c = 1'b1; end
      ACTIVE: if (cs_rise_c) begin state_d = IDLE;   stop_c  = 1'b1; end
    endcase
  end

  // Edge classification and holding-register consume decode
  always_comb begin
    active_c    = (state_q == ACTIVE);
    lead_c      = cpol_q ? sclk_fall_c : sclk_rise_c;
    trail_c     = cpol_q ? sclk_rise_c : sclk_fall_c;
    sample_c    = active_c & ~cs_rise_c & (cpha_q ? trail_c : lead_c);
    shift_c     = active_c & ~cs_rise_c & (cpha_q ? lead_c : trail_c);
    last_c      = sample_c & (bit_cnt_q == 3'd7);
    consume_c   = start_c | (last_c & cpha_q) | (shift_c & reload_pend_q);
    next_tx_c   = tx_empty ? IDLE_BYTE : hold_q;
    push_data_c = {rx_sh_q, mosi_c};
  end

  // Shift engine: sampling, bit counting, MISO byte reloads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt_q     <= 3'd0;
      rx_sh_q       <= 7'd0;
      tx_sh_q       <= 8'd0;
      first_shift_q <= 1'b0;
      reload_pend_q <= 1'b0;
    end else if (start_c) begin
      cpol_q        <= conf[1];
      cpha_q        <= conf[0];
      bit_cnt_q     <= 3'd0;
      rx_sh_q       <= 7'd0;
      tx_sh_q       <= next_tx_c;
      first_shift_q <= conf[0];
      reload_pend_q <= 1'b0;
    end else if (stop_c) begin
      bit_cnt_q     <= 3'd0;
      first_shift_q <= 1'b0;
      reload_pend_q <= 1'b0;
    end else begin
      if (sample_c) begin
        rx_sh_q <= {rx_sh_q[5:0], mosi_c};
        if (last_c) begin
          bit_cnt_q <= 3'd0;
          if (cpha_q) begin
            tx_sh_q       <= next_tx_c;
            first_shift_q <= 1'b1;
          end else begin
            reload_pend_q <= 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end
      if (shift_c) begin
        if (reload_pend_q) begin
          tx_sh_q       <= next_tx_c;
          reload_pend_q <= 1'b0;
        end else if (first_shift_q) begin
          first_shift_q <= 1'b0;
        end else begin
          tx_sh_q <= {tx_sh_q[6:0], 1'b0};
        end
      end
    end
  end

  // TX holding register; a load in the same clk as a consume keeps the new byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= 8'd0;
      tx_empty <= 1'b1;
    end else if (tx_load) begin
      hold_q   <= tx_data;
      tx_empty <= 1'b0;
    end else if (consume_c) begin
      tx_empty <= 1'b1;
    end
  end

  // FIFO push/pop qualification; a pop frees room for a same-clk push
  always_comb begin
    full_c        = (rx_count == CNT_W'(RX_DEPTH));
    do_read_c     = rx_read & (rx_count != '0);
    do_push_c     = last_c & (~full_c | do_read_c);
    overrun_set_c = last_c & full_c & ~do_read_c;
  end

  // RX FIFO storage, pointers, occupancy and sticky overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RX_DEPTH); i++) mem_q[i] <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= push_data_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_read_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      rx_count <= rx_count + CNT_W'(do_push_c) - CNT_W'(do_read_c);
      if (overrun_set_c)    rx_overrun <= 1'b1;
      else if (overrun_clr) rx_overrun <= 1'b0;
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign spi_miso    = active_c & tx_sh_q[7];
  assign spi_miso_oe = active_c;
  assign busy        = active_c;

endmodule
